// File: rtl/sram_pkg.sv
// Shared constants and FSM state type for the SRAM frame-write pixel packer.
package sram_pkg;

  localparam int DEFAULT_COLOR_WIDTH = 4;
  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_ADDR_WIDTH  = 20;
  localparam int DEFAULT_FRAME_WORDS = 76800;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } packer_state_e;

  // Counter width that stays legal when only one slot exists
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_shift_accum.sv
// Shift accumulator and slot counter; presents the left-aligned word that
// completes on the current push.
module pixel_shift_accum
  import sram_pkg::*;
#(
  parameter int COLOR_WIDTH    = DEFAULT_COLOR_WIDTH,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PIXEL_PER_ADDR = DEFAULT_DATA_WIDTH / DEFAULT_COLOR_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   init,
  input  logic                   push,
  input  logic                   last,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic [DATA_WIDTH-1:0]  word,
  output logic                   full,
  output logic                   clear
);

  localparam int CNT_W = count_width(PIXEL_PER_ADDR);
  localparam int SH_W  = $clog2(DATA_WIDTH) + 1;

  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] shifted;
  logic [CNT_W-1:0]      count;
  logic [SH_W-1:0]       shamt;

  // Pixels collect right-aligned; a short word is pushed up so the first pixel lands in the MSBs
  always_comb begin
    shifted = (acc << COLOR_WIDTH) | DATA_WIDTH'(color);
    shamt   = SH_W'((PIXEL_PER_ADDR - 1 - int'(count)) * COLOR_WIDTH);
    word    = shifted << shamt;
  end

  assign full  = push && (last || (count == CNT_W'(PIXEL_PER_ADDR - 1)));
  assign clear = (count == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (init || full) begin
      acc   <= '0;
      count <= '0;
    end else if (push) begin
      acc   <= shifted;
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sram_pixel_packer.sv
// Packs encoded pixels into SRAM words and issues them with sequential,
// wrapping addresses over a bounded frame region.
module sram_pixel_packer
  import sram_pkg::*;
#(
  parameter int          COLOR_WIDTH = DEFAULT_COLOR_WIDTH,
  parameter int          DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int          ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned FRAME_WORDS = DEFAULT_FRAME_WORDS
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_pix_valid,
  output logic                   o_pix_ready,
  input  logic [COLOR_WIDTH-1:0] i_pix_color,
  input  logic                   i_pix_last,
  output logic                   o_wr_valid,
  input  logic                   i_wr_ready,
  output logic [ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [DATA_WIDTH-1:0]  o_wr_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_wrap
);

  localparam int PIXEL_PER_ADDR = DATA_WIDTH / COLOR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FIRST_ADDR = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS - 1);

  packer_state_e         state;
  logic                  pix_fire;
  logic                  wr_fire;
  logic                  acc_init;
  logic                  acc_full;
  logic                  acc_clear;
  logic [DATA_WIDTH-1:0] acc_word;

  // A pixel may enter only when the output register is free or draining this cycle
  assign o_pix_ready  = (state == RUN) && (!o_wr_valid || i_wr_ready);
  assign pix_fire     = i_pix_valid && o_pix_ready;
  assign wr_fire      = o_wr_valid && i_wr_ready;
  assign acc_init     = (state == IDLE) && i_start;
  assign o_busy       = (state != IDLE);
  assign o_frame_done = (state == DONE);

  pixel_shift_accum #(
    .COLOR_WIDTH    (COLOR_WIDTH),
    .DATA_WIDTH     (DATA_WIDTH),
    .PIXEL_PER_ADDR (PIXEL_PER_ADDR)
  ) u_accum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .init    (acc_init),
    .push    (pix_fire),
    .last    (i_pix_last),
    .color   (i_pix_color),
    .word    (acc_word),
    .full    (acc_full),
    .clear   (acc_clear)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      o_wr_valid <= 1'b0;
      o_wr_addr  <= FIRST_ADDR;
      o_wr_data  <= '0;
      o_wrap     <= 1'b0;
    end else begin
      o_wrap <= 1'b0;

      case (state)
        IDLE: begin
          if (i_start) begin
            state     <= RUN;
            o_wr_addr <= FIRST_ADDR;
          end
        end
        RUN: begin
          if (pix_fire && i_pix_last) state <= FLUSH;
        end
        FLUSH: begin
          if (acc_clear && (!o_wr_valid || i_wr_ready)) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // The address always names the word currently held, so it advances only after a write
      if (wr_fire) begin
        if (o_wr_addr == LAST_ADDR) begin
          o_wr_addr <= FIRST_ADDR;
          o_wrap    <= 1'b1;
        end else begin
          o_wr_addr <= o_wr_addr + ADDR_WIDTH'(1);
        end
      end

      if (acc_full) begin
        o_wr_data  <= acc_word;
        o_wr_valid <= 1'b1;
      end else if (wr_fire) begin
        o_wr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_pixel_packer.sv
// Drives two packers (default region and a tiny wrapping region) in lockstep and
// checks them against a word-level frame model.
module tb_sram_pixel_packer;

  localparam int CW = 4;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int B0 = 0;
  localparam int F0 = 76800;
  localparam int B1 = 16;
  localparam int F1 = 2;
  localparam int PPA = DW / CW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_pix_valid = 1'b0;
  logic          i_pix_last = 1'b0;
  logic          i_wr_ready = 1'b0;
  logic [CW-1:0] i_pix_color = '0;

  logic          pix_ready0, wr_valid0, busy0, done0, wrap0;
  logic          pix_ready1, wr_valid1, busy1, done1, wrap1;
  logic [AW-1:0] wr_addr0, wr_addr1;
  logic [DW-1:0] wr_data0, wr_data1;

  sram_pixel_packer #(
    .COLOR_WIDTH (CW), .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
    .BASE_ADDR (B0), .FRAME_WORDS (F0)
  ) dut0 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_start (i_start),
    .i_pix_valid (i_pix_valid), .o_pix_ready (pix_ready0),
    .i_pix_color (i_pix_color), .i_pix_last (i_pix_last),
    .o_wr_valid (wr_valid0), .i_wr_ready (i_wr_ready),
    .o_wr_addr (wr_addr0), .o_wr_data (wr_data0),
    .o_busy (busy0), .o_frame_done (done0), .o_wrap (wrap0)
  );

  sram_pixel_packer #(
    .COLOR_WIDTH (CW), .DATA_WIDTH (DW), .ADDR_WIDTH (AW),
    .BASE_ADDR (B1), .FRAME_WORDS (F1)
  ) dut1 (
    .i_clk (i_clk), .i_rst_n (i_rst_n), .i_start (i_start),
    .i_pix_valid (i_pix_valid), .o_pix_ready (pix_ready1),
    .i_pix_color (i_pix_color), .i_pix_last (i_pix_last),
    .o_wr_valid (wr_valid1), .i_wr_ready (i_wr_ready),
    .o_wr_addr (wr_addr1), .o_wr_data (wr_data1),
    .o_busy (busy1), .o_frame_done (done1), .o_wrap (wrap1)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [DW-1:0] data;
    int            idx;
  } word_t;

  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  word_t mq[$];
  int    mpix[$];
  int    mword_cnt = 0;
  bit    mrun, mflush, mdone, mwrap0, mwrap1, macc;
  int    last_acc_cyc = 0;
  int    done_cyc = 0;
  int    wraps1 = 0;
  int    log_data[$];
  int    log_addr0[$];
  int    log_addr1[$];
  int    pix_buf[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] packWord();
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < mpix.size(); i++) w |= DW'(mpix[i]) << (DW - CW * (i + 1));
    return w;
  endfunction

  function automatic int expAddr(input int base, input int fw, input int k);
    return base + (k % fw);
  endfunction

  task automatic checkOutput();
    bit exp_ready;
    bit exp_valid;
    exp_ready = mrun && (mq.size() == 0 || i_wr_ready);
    exp_valid = (mq.size() > 0);
    chk("pix_ready0", pix_ready0, exp_ready);
    chk("pix_ready1", pix_ready1, exp_ready);
    chk("wr_valid0", wr_valid0, exp_valid);
    chk("wr_valid1", wr_valid1, exp_valid);
    if (exp_valid) begin
      chk("wr_data0", wr_data0, mq[0].data);
      chk("wr_data1", wr_data1, mq[0].data);
      chk("wr_addr0", wr_addr0, expAddr(B0, F0, mq[0].idx));
      chk("wr_addr1", wr_addr1, expAddr(B1, F1, mq[0].idx));
    end
    chk("busy0", busy0, mrun | mflush | mdone);
    chk("busy1", busy1, mrun | mflush | mdone);
    chk("frame_done0", done0, mdone);
    chk("frame_done1", done1, mdone);
    chk("wrap0", wrap0, mwrap0);
    chk("wrap1", wrap1, mwrap1);
    if (wr_valid0 === 1'b1 && i_wr_ready) begin
      log_data.push_back(int'(wr_data0));
      log_addr0.push_back(int'(wr_addr0));
    end
    if (wr_valid1 === 1'b1 && i_wr_ready) log_addr1.push_back(int'(wr_addr1));
    if (wrap1 === 1'b1) wraps1++;
    if (done0 === 1'b1) done_cyc = cyc;
  endtask

  // Advance the frame model by one clock using the inputs presented this cycle
  task automatic modelUpdate();
    bit    exp_ready, pix_acc, wr_hs, idle, n_run, n_flush, n_done;
    word_t w;
    exp_ready = mrun && (mq.size() == 0 || i_wr_ready);
    pix_acc   = i_pix_valid && exp_ready;
    wr_hs     = (mq.size() > 0) && i_wr_ready;
    idle      = !(mrun || mflush || mdone);
    mwrap0 = 1'b0;
    mwrap1 = 1'b0;
    if (wr_hs) begin
      mwrap0 = ((mq[0].idx % F0) == F0 - 1);
      mwrap1 = ((mq[0].idx % F1) == F1 - 1);
      mq.delete(0);
    end
    macc    = pix_acc;
    n_run   = mrun;
    n_flush = mflush;
    n_done  = 1'b0;
    if (pix_acc) begin
      mpix.push_back(int'(i_pix_color));
      if (mpix.size() == PPA || i_pix_last) begin
        w.data = packWord();
        w.idx  = mword_cnt;
        mq.push_back(w);
        mword_cnt++;
        mpix.delete();
      end
      if (i_pix_last) begin
        last_acc_cyc = cyc;
        n_run   = 1'b0;
        n_flush = 1'b1;
      end
    end
    if (idle && i_start) begin
      n_run = 1'b1;
      mword_cnt = 0;
      mpix.delete();
    end
    if (mflush && mq.size() == 0) begin
      n_flush = 1'b0;
      n_done  = 1'b1;
    end
    mrun   = n_run;
    mflush = n_flush;
    mdone  = n_done;
    cyc++;
  endtask

  task automatic applyStimulus(input bit start, input bit valid, input logic [CW-1:0] color,
                               input bit last, input bit rdy);
    @(negedge i_clk);
    i_start     = start;
    i_pix_valid = valid;
    i_pix_color = color;
    i_pix_last  = last;
    i_wr_ready  = rdy;
    #1;
    checkOutput();
    modelUpdate();
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_pix_valid = 1'b0;
    i_pix_last  = 1'b0;
    i_pix_color = '0;
    i_wr_ready  = 1'b0;
    #1;
    chk("rst_pix_ready", pix_ready0, 0);
    chk("rst_wr_valid", wr_valid0, 0);
    chk("rst_wr_addr0", wr_addr0, B0);
    chk("rst_wr_addr1", wr_addr1, B1);
    chk("rst_wr_data", wr_data0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_frame_done", done0, 0);
    chk("rst_wrap", wrap1, 0);
    mq.delete();
    mpix.delete();
    mrun = 0; mflush = 0; mdone = 0; mwrap0 = 0; mwrap1 = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // mode 0: always ready; 1: random valid/ready/start; 2: stall 5 cycles after first word
  task automatic runFrame(input int mode, input bit glitch);
    int idx, guard, blk_left;
    bit rdy, vld, st;
    log_data.delete();
    log_addr0.delete();
    log_addr1.delete();
    wraps1   = 0;
    done_cyc = -1;
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    idx = 0;
    guard = 0;
    blk_left = 5;
    while (idx < pix_buf.size() && guard < 2000) begin
      rdy = 1'b1;
      vld = 1'b1;
      st  = 1'b0;
      if (mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
        vld = ($urandom_range(0, 3) != 0);
        st  = ($urandom_range(0, 7) == 0);
      end
      if (mode == 2 && mq.size() > 0 && blk_left > 0) begin
        rdy = 1'b0;
        blk_left--;
      end
      if (glitch && (idx == 2 || idx == 5)) st = 1'b1;
      applyStimulus(st, vld, CW'(pix_buf[idx]), (idx == pix_buf.size() - 1), rdy);
      if (macc) idx++;
      guard++;
    end
    while ((mrun || mflush || mdone) && guard < 2000) begin
      rdy = (mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b1;
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), CW'($urandom), 1'b0, rdy);
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      failures++;
      $display("[TB] FAIL frame_timeout observed=%0d expected<2000", guard);
    end
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    doReset();

    $display("[TB] full word 1,2,3,4");
    pix_buf = '{1, 2, 3, 4};
    runFrame(0, 1'b0);
    chk("t1_words", log_data.size(), 1);
    chk("t1_data", log_data[0], 16'h1234);
    chk("t1_addr", log_addr0[0], 0);

    $display("[TB] partial word A,B");
    pix_buf = '{10, 11};
    runFrame(0, 1'b0);
    chk("t2_data", log_data[0], 16'hAB00);
    chk("t2_addr0", log_addr0[0], B0);
    chk("t2_addr1", log_addr1[0], B1);
    chk("t2_done_latency", done_cyc - last_acc_cyc, 2);

    $display("[TB] backpressure 8 pixels");
    pix_buf = '{1, 2, 3, 4, 5, 6, 7, 8};
    runFrame(2, 1'b0);
    chk("t3_words", log_data.size(), 2);
    chk("t3_data0", log_data[0], 16'h1234);
    chk("t3_data1", log_data[1], 16'h5678);
    chk("t3_addr1", log_addr0[1], 1);

    $display("[TB] wrap with 12 pixels");
    pix_buf = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    runFrame(0, 1'b0);
    chk("t4_addr_a", log_addr1[0], 16'h10);
    chk("t4_addr_b", log_addr1[1], 16'h11);
    chk("t4_addr_c", log_addr1[2], 16'h10);
    chk("t4_data_c", log_data[2], 16'h9ABC);
    chk("t4_wraps", wraps1, 1);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
    doReset();
    pix_buf = '{9, 9, 9, 9};
    runFrame(0, 1'b0);
    chk("t5_words", log_data.size(), 1);
    chk("t5_data", log_data[0], 16'h9999);
    chk("t5_addr0", log_addr0[0], B0);
    chk("t5_addr1", log_addr1[0], B1);

    $display("[TB] start pulsed during run");
    pix_buf = '{1, 2, 3, 4, 5, 6, 7, 8};
    runFrame(0, 1'b1);
    chk("t6_data0", log_data[0], 16'h1234);
    chk("t6_data1", log_data[1], 16'h5678);
    chk("t6_addr1", log_addr0[1], 1);

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      pix_buf.delete();
      for (int p = 0; p < int'($urandom_range(1, 19)); p++) pix_buf.push_back(int'($urandom_range(0, 15)));
      runFrame(1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_pixel_packer.md
# sram_pixel_packer

Packs a stream of fixed-width encoded pixel colours into SRAM-width words and issues them, with sequential addresses, to the SRAM write port under a valid/ready handshake. It sits between the colour encoder and the SRAM controller on the frame-write path. It adds frame start/end control, partial-word flush, backpressure and address wrap-around on a bounded frame region.

## Interface
Parameters:
- COLOR_WIDTH, 4, bits per encoded pixel.
- DATA_WIDTH, 16, SRAM word width; must be an integer multiple of COLOR_WIDTH.
- PIXEL_PER_ADDR, DATA_WIDTH/COLOR_WIDTH (derived localparam, not overridable), pixels per word.
- ADDR_WIDTH, 20, SRAM address width.
- BASE_ADDR, 0, first word address of the frame region.
- FRAME_WORDS, 76800, words in the frame region (640x480 at 4 pixels per word).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  start a frame; honoured only in IDLE.
- i_pix_valid  in  1  pixel present.
- o_pix_ready  out  1  pixel accepted when valid && ready.
- i_pix_color  in  COLOR_WIDTH  encoded colour.
- i_pix_last  in  1  last pixel of the frame; qualified by the pixel handshake.
- o_wr_valid  out  1  word and address valid.
- i_wr_ready  in  1  SRAM controller takes the word when valid && ready.
- o_wr_addr  out  ADDR_WIDTH  word address.
- o_wr_data  out  DATA_WIDTH  packed word.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse at the end of a frame.
- o_wrap  out  1  one-cycle pulse when the address wraps to BASE_ADDR.

## Operation
- States and transitions:
  - IDLE -> RUN on i_start. On that transition: count = 0, accumulator = 0, address = BASE_ADDR.
  - RUN -> FLUSH on acceptance of a pixel with i_pix_last = 1.
  - FLUSH -> DONE when the output register is empty, or is being drained in the current cycle.
  - DONE -> IDLE after one cycle. o_frame_done = 1 only in DONE.
- o_pix_ready = (state == RUN) && (!o_wr_valid || i_wr_ready).
- Packing order: the first pixel of a word occupies the MSBs, i.e. acc = {acc[DATA_WIDTH-COLOR_WIDTH-1:0], color}.
- A word completes on acceptance of the PIXEL_PER_ADDR-th pixel, or on acceptance of a pixel with last = 1.
  - A partial word is left-aligned; unused LSB slots are zero. Example: 2 pixels A, B give 0xAB00.
  - On completion, the word loads the output register, o_wr_valid rises, and the accumulator and count clear.
- Address handling:
  - o_wr_addr holds the address of the current word.
  - After each write handshake the address increments.
  - If the address equals BASE_ADDR + FRAME_WORDS - 1, it instead reloads BASE_ADDR and o_wrap pulses in the following cycle.
- Address arithmetic is ADDR_WIDTH bits unsigned. BASE_ADDR + FRAME_WORDS must be <= 2^ADDR_WIDTH.
- Ignored inputs:
  - i_start outside IDLE is ignored.
  - i_pix_valid outside RUN is ignored (ready is low).
- Holding rules: o_wr_data and o_wr_addr stay stable while o_wr_valid && !i_wr_ready.

## Timing
- Reset values: state IDLE, o_pix_ready 0, o_wr_valid 0, o_wr_addr BASE_ADDR, o_wr_data 0, o_busy 0, o_frame_done 0, o_wrap 0. Counter and accumulator are 0.
- Reset mid-frame discards any partial word and any pending output word; no flush occurs.
- Latency: a completing pixel accepted in cycle N gives o_wr_valid = 1 in cycle N+1.
- Throughput: with i_wr_ready held at 1, one pixel is accepted per cycle, giving one word per PIXEL_PER_ADDR cycles.
- Simultaneous write handshake and completing pixel in the same cycle: the output register reloads, and o_wr_valid stays 1 with the new word at the incremented address.
- i_start to first o_pix_ready = 1: one cycle.
- last accepted in cycle N with i_wr_ready held at 1:
  - N+1: o_wr_valid = 1.
  - N+2: DONE, o_frame_done = 1.
  - N+3: IDLE.
- Frame ending exactly on a word boundary: no extra zero word is written.

## Structure
- Package sram_pkg holds the DEFAULT_COLOR_WIDTH, DEFAULT_DATA_WIDTH, DEFAULT_ADDR_WIDTH and DEFAULT_FRAME_WORDS constants and the packer_state_e enum (IDLE, RUN, FLUSH, DONE).
- One sub-module, pixel_shift_accum, holds the shift accumulator and slot counter. Its outputs are word, full and clear.
- The top level holds the FSM, the output register and the address generator.

## Test plan
- PPA = 4; pixels 1, 2, 3, 4, with last on the 4th, i_wr_ready = 1 -> one write 0x1234 at addr 0, then o_frame_done; no second word.
- Pixels A, B with last on B -> write 0xAB00 at the base address, then o_frame_done two cycles after B is accepted.
- 8 pixels 1..8 with i_wr_ready held low for 5 cycles after the first word -> 0x1234 held stable, o_pix_ready low while it is blocked; then writes 0x1234 at 0 and 0x5678 at 1, with no pixel lost.
- FRAME_WORDS = 2, BASE_ADDR = 0x10, 12 pixels -> addresses 0x10, 0x11, 0x10; o_wrap pulses once after the write at 0x11.
- Assert i_rst_n low after 2 pixels of a word -> all outputs at reset values. After i_start and pixels 9, 9, 9, 9, write 0x9999 at BASE_ADDR.
- i_start pulsed during RUN -> no effect on the address or the accumulator.
